// File: rtl/jpg_block_packer.sv
// Buffers one 8x8 interleaved RGB block and re-emits it as R, G, B planar AXIS packets.
// Define JPG_PACKER_PINGPONG_EN for a two-bank buffer that overlaps filling with sending.
module jpg_block_packer #(
  parameter int unsigned PIXEL_BITS             = 8,
  parameter int unsigned DATA_DEPTH             = 8,
  parameter int unsigned PIXEL_COUNT            = DATA_DEPTH * DATA_DEPTH,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 4 * PIXEL_BITS
) (
  input  logic                                axis_aclk,
  input  logic                                axis_areset,
  input  logic [3*PIXEL_BITS-1:0]             s00_axis_tdata,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic                                err_framing
);
  localparam int unsigned CW    = $clog2(PIXEL_COUNT);
  localparam int unsigned WORDS = PIXEL_COUNT / 4;
  localparam int unsigned WW    = $clog2(WORDS);
`ifdef JPG_PACKER_PINGPONG_EN
  localparam int unsigned AW = CW + 1;
`else
  localparam int unsigned AW = CW;
`endif
  localparam logic [CW-1:0] LAST_PIX  = CW'(PIXEL_COUNT - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

  logic [3*PIXEL_BITS-1:0]           mem [0:(2**AW)-1];
  logic                              run;
  logic [CW-1:0]                     pix_cnt;
  logic                              s_hs, term, m_hs;
  logic [AW-1:0]                     wr_addr, rd_addr;
  logic [CW:0]                       rd_len;
  logic [WW-1:0]                     gen_word;
  logic [1:0]                        gen_plane;
  logic                              gen_valid, issue, gen_last;
  logic [CW-1:0]                     rd_idx;
  logic [3*PIXEL_BITS-1:0]           rd_pix;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] gen_data, p_data;
  logic                              p_valid, p_last, p_free, o_load;

  assign s_hs           = s00_axis_tvalid && s00_axis_tready;
  assign term           = s_hs && (s00_axis_tlast || pix_cnt == LAST_PIX);
  assign m_hs           = m00_axis_tvalid && m00_axis_tready;
  assign o_load         = p_valid && (!m00_axis_tvalid || m00_axis_tready);
  assign p_free         = !p_valid || o_load;
  assign issue          = gen_valid && p_free;
  assign gen_last       = issue && gen_plane == 2'd2 && gen_word == LAST_WORD;
  assign m00_axis_tstrb = '1;

`ifdef JPG_PACKER_PINGPONG_EN
  logic        fill_bank, send_bank;
  logic [1:0]  bank_full;
  logic [CW:0] fill_len [0:1];

  assign s00_axis_tready = run && !bank_full[fill_bank];
  assign gen_valid       = bank_full[send_bank];
  assign rd_len          = fill_len[send_bank];
  assign wr_addr         = {fill_bank, pix_cnt};

  // A bank is released once its last word has moved into the prefetch stage,
  // so the next bank can issue on the very next cycle.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      fill_bank   <= 1'b0;
      send_bank   <= 1'b0;
      bank_full   <= '0;
      fill_len[0] <= '0;
      fill_len[1] <= '0;
    end else begin
      if (term) begin
        bank_full[fill_bank] <= 1'b1;
        fill_bank            <= !fill_bank;
        fill_len[fill_bank]  <= (CW+1)'(pix_cnt) + (CW+1)'(1);
      end
      if (gen_last) begin
        bank_full[send_bank] <= 1'b0;
        send_bank            <= !send_bank;
      end
    end
  end
`else
  localparam logic [1:0] FILL = 2'd0, SEND_R = 2'd1, SEND_G = 2'd2, SEND_B = 2'd3;
  logic [1:0]  state;
  logic        gen_on;
  logic [CW:0] fill_len;

  assign s00_axis_tready = run && state == FILL;
  assign gen_valid       = gen_on;
  assign rd_len          = fill_len;
  assign wr_addr         = pix_cnt;

  // The word generator runs ahead of the output; state follows delivered planes.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state    <= FILL;
      gen_on   <= 1'b0;
      fill_len <= '0;
    end else begin
      if (term) begin
        gen_on   <= 1'b1;
        fill_len <= (CW+1)'(pix_cnt) + (CW+1)'(1);
      end else if (gen_last) begin
        gen_on <= 1'b0;
      end
      case (state)
        FILL:   if (term) state <= SEND_R;
        SEND_R: if (m_hs && m00_axis_tlast) state <= SEND_G;
        SEND_G: if (m_hs && m00_axis_tlast) state <= SEND_B;
        SEND_B: if (m_hs && m00_axis_tlast) state <= FILL;
      endcase
    end
  end
`endif

  // Pixels past the received length read as zero, which zero-fills short blocks.
  always_comb begin
    gen_data = '0;
    rd_idx   = '0;
    rd_addr  = '0;
    rd_pix   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rd_idx = {gen_word, 2'(k)};
`ifdef JPG_PACKER_PINGPONG_EN
      rd_addr = {send_bank, rd_idx};
`else
      rd_addr = rd_idx;
`endif
      rd_pix = mem[rd_addr];
      if ({1'b0, rd_idx} < rd_len)
        gen_data[k*PIXEL_BITS +: PIXEL_BITS] = rd_pix[gen_plane*PIXEL_BITS +: PIXEL_BITS];
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (s_hs) mem[wr_addr] <= s00_axis_tdata;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      run             <= 1'b0;
      pix_cnt         <= '0;
      err_framing     <= 1'b0;
      gen_word        <= '0;
      gen_plane       <= '0;
      p_valid         <= 1'b0;
      p_last          <= 1'b0;
      p_data          <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else begin
      run <= 1'b1;
      if (s_hs) pix_cnt <= term ? '0 : pix_cnt + CW'(1);
      if (term && (s00_axis_tlast != (pix_cnt == LAST_PIX))) err_framing <= 1'b1;

      if (issue) begin
        if (gen_word == LAST_WORD) begin
          gen_word  <= '0;
          gen_plane <= (gen_plane == 2'd2) ? 2'd0 : gen_plane + 2'd1;
        end else begin
          gen_word <= gen_word + WW'(1);
        end
      end

      if (issue) begin
        p_valid <= 1'b1;
        p_data  <= gen_data;
        p_last  <= gen_word == LAST_WORD;
      end else if (o_load) begin
        p_valid <= 1'b0;
      end

      if (o_load) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata  <= p_data;
        m00_axis_tlast  <= p_last;
      end else if (m_hs) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
